timer_ctrl: RTL and testbench
=============================

# timer_ctrl

Wishbone master that sequences the SoC Timer peripheral on behalf of a simple start/stop request port. On a start request it programs prescaler, compare and counter, enables the timer, then polls the CONTROL flag at a fixed interval, reporting each expiry as a pulse. In periodic mode it clears the flag and keeps the timer running; in one-shot mode it disables the timer after the first expiry. It sits between a hardware requester and the Timer's Wishbone slave port.

## Interface
- BASE_ADDR, 32'h0000_0000: byte base of the Timer; registers at +0x0 CONTROL, +0x4 COUNTER, +0x8 PRESCALER, +0xC COMPARE.
- POLL_GAP, 16: idle cycles between CONTROL polls (≥1).
- ACK_TIMEOUT, 8: cycles a read may wait for wb_ack_i before aborting (≥2).
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle request; sampled only in IDLE.
- stop_i  in  1  abort request; ignored in IDLE.
- prescaler_i  in  32  latched on accepted start.
- compare_i  in  32  latched on accepted start.
- periodic_i  in  1  latched on accepted start; 1 = periodic.
- busy_o  out  1  state != IDLE.
- expired_o  out  1  one-cycle pulse per detected expiry.
- expire_cnt_o  out  16  expiries since last start, saturating at 16'hFFFF.
- err_o  out  1  sticky read-timeout flag; cleared on accepted start.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master strobes.
- wb_sel_o  out  4  always 4'hF when stb high, else 0.
- wb_adr_o  out  32  byte address.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  read acknowledge.

## Operation
- Reset: state IDLE; all outputs 0 (wb_adr_o, wb_dat_o, expire_cnt_o included); latched config 0.
- Writes are posted: cyc/stb/we high for exactly one cycle; wb_ack_i not awaited. Reads: cyc/stb high, we low, held until wb_ack_i or timeout.
- States: IDLE, W_DIS, W_PSC, W_CMP, W_CNT, W_EN, GAP, RD, GUARD, CLR, STOP.
- IDLE --start_i--> W_DIS (CONTROL=0) -> W_PSC (PRESCALER) -> W_CMP (COMPARE) -> W_CNT (COUNTER=0) -> W_EN (CONTROL=0x3: enable + clear flag) -> GAP.
- GAP: counts POLL_GAP cycles, bus idle, then RD (address BASE_ADDR+0x0).
- RD on ack: if wb_dat_i[1]=1: expired_o pulse, expire_cnt_o++; periodic -> CLR, one-shot -> STOP. If 0 -> GUARD.
- CLR: write CONTROL=0x3 -> GUARD. GUARD: one idle bus cycle, wb_ack_i ignored (absorbs trailing ack of a registered slave) -> GAP.
- RD timeout (ACK_TIMEOUT cycles without ack): err_o=1, drop cyc/stb -> STOP.
- STOP: write CONTROL=0 -> IDLE.
- stop_i latches a pending-stop bit. Taken in any write state, GAP or GUARD: next state STOP, skipping remaining writes. In RD: the read completes (result discarded, no expiry counted) then STOP. Pending bit cleared on entering STOP.
- start_i while busy ignored. start_i and stop_i together in IDLE: start accepted, stop ignored.
- Accepted start clears expire_cnt_o and err_o.

## Timing
- Start sampled at edge N: W_DIS write on bus in cycle N+1; five writes occupy N+1..N+5; GAP begins N+6; first RD stb at N+6+POLL_GAP.
- expired_o asserts the cycle after the ack edge carrying flag=1; expire_cnt_o updates same cycle.
- Back-to-back bus activity never spans an ack-accepting RD immediately after another RD (GUARD or a write always intervenes).
- Periodic poll period with flag=0: RD(ack latency)+1 GUARD+POLL_GAP.
- Reset mid-operation: bus strobes low the cycle after rst asserts; no disable write issued.

## Configuration
- TIMER_CTRL_PERIODIC_EN defined: behaviour as above.
- Undefined: periodic_i ignored, CLR state absent; every expiry goes to STOP (one-shot only); expire_cnt_o max 1.

## Test plan
- Start, prescaler=3, compare=9, one-shot, model timer -> writes 0, 3, 9, 0, 0x3 to +0x0,+0x8,+0xC,+0x4,+0x0 in cycles N+1..N+5; one expired_o pulse; final write CONTROL=0; busy_o falls; expire_cnt_o=1.
- Periodic, compare=4, prescaler=0, run 5 expiries -> 5 expired_o pulses, CONTROL=0x3 write after each, expire_cnt_o=5, busy_o stays 1.
- stop_i during W_CMP -> no COUNTER/enable writes; next write CONTROL=0; IDLE, expire_cnt_o=0.
- stop_i while RD pending, slave acks flag=1 -> no expired_o, CONTROL=0 written, IDLE.
- Slave never acks, ACK_TIMEOUT=8 -> stb dropped after 8 cycles, err_o=1, CONTROL=0 write, IDLE; next start clears err_o.
- start_i while busy, and rst mid-GAP -> start ignored; after rst all outputs 0, state IDLE.

Source files
------------

// File: rtl/timer_ctrl.sv
// timer_ctrl: Wishbone master that programs the SoC Timer, polls its CONTROL flag and reports expiries.
// Optional feature macro TIMER_CTRL_PERIODIC_EN adds periodic mode (CLR state); without it every expiry stops the timer.
module timer_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          POLL_GAP    = 16,
  parameter int          ACK_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [31:0] prescaler_i,
  input  logic [31:0] compare_i,
  input  logic        periodic_i,
  output logic        busy_o,
  output logic        expired_o,
  output logic [15:0] expire_cnt_o,
  output logic        err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam logic [31:0] ADR_CONTROL   = BASE_ADDR + 32'h0;
  localparam logic [31:0] ADR_COUNTER   = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADR_PRESCALER = BASE_ADDR + 32'h8;
  localparam logic [31:0] ADR_COMPARE   = BASE_ADDR + 32'hC;

  // One counter serves both the poll gap and the read timeout; the two never overlap.
  localparam int              TICK_MAX = (POLL_GAP > ACK_TIMEOUT) ? POLL_GAP : ACK_TIMEOUT;
  localparam int              TW       = $clog2(TICK_MAX + 1);
  localparam logic [TW-1:0]   GAP_LAST = TW'(POLL_GAP - 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, W_DIS, W_PSC, W_CMP, W_CNT, W_EN, GAP, RD, GUARD,
`ifdef TIMER_CTRL_PERIODIC_EN
    CLR,
`endif
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          pend_q, pend_d;
  logic [31:0]   psc_q, psc_d;
  logic [31:0]   cmp_q, cmp_d;
  logic          busy_q, busy_d;
  logic          expired_q, expired_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          stop_req;
  logic          bus_wr, bus_rd;

`ifdef TIMER_CTRL_PERIODIC_EN
  logic per_q, per_d;
  logic unused_dat;
  assign unused_dat = ^{wb_dat_i[31:2], wb_dat_i[0]};
`else
  logic unused_dat;
  assign unused_dat = ^{wb_dat_i[31:2], wb_dat_i[0], periodic_i};
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    tick_d    = tick_q + 1'b1;
    pend_d    = pend_q;
    psc_d     = psc_q;
    cmp_d     = cmp_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    expired_d = 1'b0;
`ifdef TIMER_CTRL_PERIODIC_EN
    per_d     = per_q;
`endif
    stop_req  = pend_q | stop_i;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = W_DIS;
          psc_d   = prescaler_i;
          cmp_d   = compare_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          pend_d  = 1'b0;
`ifdef TIMER_CTRL_PERIODIC_EN
          per_d   = periodic_i;
`endif
        end
      end
      W_DIS: state_d = stop_req ? STOP : W_PSC;
      W_PSC: state_d = stop_req ? STOP : W_CMP;
      W_CMP: state_d = stop_req ? STOP : W_CNT;
      W_CNT: state_d = stop_req ? STOP : W_EN;
      W_EN:  state_d = stop_req ? STOP : GAP;
      GAP: begin
        if (stop_req)               state_d = STOP;
        else if (tick_q == GAP_LAST) state_d = RD;
      end
      RD: begin
        if (wb_ack_i) begin
          // A pending stop lets the read finish but throws its result away.
          if (stop_req) begin
            state_d = STOP;
          end else if (wb_dat_i[1]) begin
            expired_d = 1'b1;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`ifdef TIMER_CTRL_PERIODIC_EN
            state_d = per_q ? CLR : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            state_d = GUARD;
          end
        end else if (tick_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = STOP;
        end
      end
`ifdef TIMER_CTRL_PERIODIC_EN
      CLR:   state_d = stop_req ? STOP : GUARD;
`endif
      GUARD: state_d = stop_req ? STOP : GAP;
      STOP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) tick_d = '0;
    if (state_d == STOP)
      pend_d = 1'b0;
    else if (stop_i && state_q != IDLE && state_d != IDLE)
      pend_d = 1'b1;

    // Bus outputs are registered, so they are decoded from the state being entered.
    bus_wr = 1'b0;
    bus_rd = 1'b0;
    adr_d  = '0;
    dat_d  = '0;
    case (state_d)
      W_DIS, STOP: begin bus_wr = 1'b1; adr_d = ADR_CONTROL;   dat_d = 32'h0;  end
      W_PSC:       begin bus_wr = 1'b1; adr_d = ADR_PRESCALER; dat_d = psc_d;  end
      W_CMP:       begin bus_wr = 1'b1; adr_d = ADR_COMPARE;   dat_d = cmp_d;  end
      W_CNT:       begin bus_wr = 1'b1; adr_d = ADR_COUNTER;   dat_d = 32'h0;  end
      W_EN:        begin bus_wr = 1'b1; adr_d = ADR_CONTROL;   dat_d = 32'h3;  end
`ifdef TIMER_CTRL_PERIODIC_EN
      CLR:         begin bus_wr = 1'b1; adr_d = ADR_CONTROL;   dat_d = 32'h3;  end
`endif
      RD:          begin bus_rd = 1'b1; adr_d = ADR_CONTROL;                   end
      default: ;
    endcase
    cyc_d  = bus_wr | bus_rd;
    we_d   = bus_wr;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      pend_q    <= 1'b0;
      psc_q     <= '0;
      cmp_q     <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
`ifdef TIMER_CTRL_PERIODIC_EN
      per_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      state_q   <= state_d;
      tick_q    <= tick_d;
      pend_q    <= pend_d;
      psc_q     <= psc_d;
      cmp_q     <= cmp_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
`ifdef TIMER_CTRL_PERIODIC_EN
      per_q     <= per_d;
`endif
    end
  end

  assign busy_o       = busy_q;
  assign expired_o    = expired_q;
  assign expire_cnt_o = cnt_q;
  assign err_o        = err_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = we_q;
  assign wb_sel_o     = {4{cyc_q}};
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: behavioural Timer slave, bus/expiry logs and per-scenario checks.
`timescale 1ns/1ps
module tb_timer_ctrl;

  localparam logic [31:0] BASE        = 32'h4000_0100;
  localparam int          POLL_GAP    = 16;
  localparam int          ACK_TIMEOUT = 8;
`ifdef TIMER_CTRL_PERIODIC_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0, stop_i = 1'b0, periodic_i = 1'b0;
  logic [31:0] prescaler_i = '0, compare_i = '0;
  logic        busy_o, expired_o, err_o;
  logic [15:0] expire_cnt_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;

  timer_ctrl #(.BASE_ADDR(BASE), .POLL_GAP(POLL_GAP), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
    .prescaler_i(prescaler_i), .compare_i(compare_i), .periodic_i(periodic_i),
    .busy_o(busy_o), .expired_o(expired_o), .expire_cnt_o(expire_cnt_o), .err_o(err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  always @(posedge clk) edge_n = edge_n + 1;

  typedef struct { int cyc; logic [31:0] adr; logic [31:0] dat; } wr_t;
  typedef struct { int cyc; bit flag; } ack_t;
  wr_t  wr_q[$];
  ack_t ack_q[$];
  int   rd_start_q[$];
  int   pulse_q[$];
  int   rd_cycles;
  int   proto_err = 0;

  // Behavioural SoC Timer: prescaled counter, flag on reaching compare.
  bit        t_en, t_flag;
  bit [31:0] t_psc, t_cmp, t_cnt, t_pdiv;
  int        ack_lat = 0;
  bit        no_ack = 0, force_flag = 0, trail_ack = 0;
  int        age = 0;
  bit        prev_rd = 0, acked_prev = 0;
  int        mon_cyc;
  wr_t       mw;
  ack_t      ma;

  always @(negedge clk) begin
    mon_cyc = edge_n + 1;
    if (!rst && (wb_sel_o !== (wb_stb_o ? 4'hF : 4'h0) || wb_cyc_o !== wb_stb_o)) proto_err++;
    if (expired_o === 1'b1) pulse_q.push_back(mon_cyc);
    if (wb_stb_o === 1'b1 && wb_we_o === 1'b1) begin
      mw.cyc = mon_cyc; mw.adr = wb_adr_o; mw.dat = wb_dat_o;
      wr_q.push_back(mw);
      case (wb_adr_o - BASE)
        32'h0: begin t_en = wb_dat_o[0]; if (wb_dat_o[1]) t_flag = 1'b0; end
        32'h4: t_cnt = wb_dat_o;
        32'h8: begin t_psc = wb_dat_o; t_pdiv = 0; end
        32'hC: t_cmp = wb_dat_o;
        default: proto_err++;
      endcase
    end
    if (t_en) begin
      if (t_pdiv >= t_psc) begin
        t_pdiv = 0;
        if (t_cnt >= t_cmp) begin t_flag = 1'b1; t_cnt = 0; end
        else t_cnt = t_cnt + 1;
      end else t_pdiv = t_pdiv + 1;
    end
    if (wb_stb_o === 1'b1 && wb_we_o === 1'b0) begin
      if (!prev_rd) rd_start_q.push_back(mon_cyc);
      if (wb_adr_o !== BASE) proto_err++;
      rd_cycles++;
      if (!no_ack && age == ack_lat) begin
        wb_ack_i = 1'b1;
        wb_dat_i = {30'b0, t_flag | force_flag, t_en};
        ma.cyc = mon_cyc; ma.flag = t_flag | force_flag;
        ack_q.push_back(ma);
        acked_prev = 1'b1;
      end else begin
        wb_ack_i = 1'b0;
        wb_dat_i = $urandom;
      end
      age++;
      prev_rd = 1'b1;
    end else begin
      // Optional trailing ack, as a registered slave would produce, presented with flag=1.
      wb_ack_i = trail_ack && acked_prev;
      wb_dat_i = 32'h2;
      acked_prev = 1'b0;
      age = 0;
      prev_rd = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    wr_q.delete(); ack_q.delete(); rd_start_q.delete(); pulse_q.delete();
    rd_cycles = 0;
  endtask

  // Presents a start at a negedge; n is the number of the edge that samples it.
  task automatic do_start(input logic [31:0] psc, input logic [31:0] cmp, input bit per, output int n);
    prescaler_i = psc; compare_i = cmp; periodic_i = per; start_i = 1'b1;
    n = edge_n + 1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy_o && k < budget) begin @(negedge clk); k++; end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy_o=%b after %0d cycles, required 0", name, busy_o, budget);
    end
  endtask

  function automatic int find_wr(input int c);
    for (int i = 0; i < wr_q.size(); i++) if (wr_q[i].cyc == c) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++;
    if ({busy_o, expired_o, err_o} !== 3'b000) begin
      errors++; $display("FAIL reset_status: busy/exp/err=%b required 000", {busy_o, expired_o, err_o});
    end
    checks++;
    if (expire_cnt_o !== 16'h0) begin
      errors++; $display("FAIL reset_cnt: expire_cnt_o=%h required 0000", expire_cnt_o);
    end
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o} !== '0) begin
      errors++; $display("FAIL reset_bus: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h required all 0",
                         wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_oneshot(input logic [31:0] psc, input logic [31:0] cmp, input int lat);
    int n, nflag;
    logic [31:0] exp_adr[5];
    logic [31:0] exp_dat[5];
    ack_t la;
    clear_logs();
    ack_lat = lat; no_ack = 0; force_flag = 0; trail_ack = 0;
    exp_adr = '{BASE, BASE + 32'h8, BASE + 32'hC, BASE + 32'h4, BASE};
    exp_dat = '{32'h0, psc, cmp, 32'h0, 32'h3};
    do_start(psc, cmp, 1'b0, n);
    wait_idle(4000, "oneshot");
    checks++;
    if (wr_q.size() != 6) begin
      errors++; $display("FAIL oneshot_nwrites: %0d writes, required 6", wr_q.size());
    end
    for (int i = 0; i < 5 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i].cyc != n + 1 + i || wr_q[i].adr !== exp_adr[i] || wr_q[i].dat !== exp_dat[i]) begin
        errors++;
        $display("FAIL oneshot_write%0d: cyc=%0d adr=%h dat=%h, required cyc=%0d adr=%h dat=%h",
                 i, wr_q[i].cyc, wr_q[i].adr, wr_q[i].dat, n + 1 + i, exp_adr[i], exp_dat[i]);
      end
    end
    checks++;
    if (rd_start_q.size() == 0 || rd_start_q[0] != n + 6 + POLL_GAP) begin
      errors++; $display("FAIL oneshot_first_read: %0d reads, first at %0d, required cycle %0d",
                         rd_start_q.size(), rd_start_q.size() ? rd_start_q[0] : -1, n + 6 + POLL_GAP);
    end
    if (ack_q.size() == 0) begin
      checks++; errors++; $display("FAIL oneshot_acks: no read acknowledged, required at least 1");
    end else begin
      la = ack_q[ack_q.size() - 1];
      nflag = 0;
      foreach (ack_q[i]) nflag += ack_q[i].flag;
      checks++;
      if (nflag != 1 || la.flag != 1'b1) begin
        errors++; $display("FAIL oneshot_flags: %0d flag reads, last flag=%0b, required 1 and 1", nflag, la.flag);
      end
      checks++;
      if (pulse_q.size() != 1 || pulse_q[0] != la.cyc + 1) begin
        errors++; $display("FAIL oneshot_pulse: %0d pulses first at %0d, required 1 at %0d",
                           pulse_q.size(), pulse_q.size() ? pulse_q[0] : -1, la.cyc + 1);
      end
      checks++;
      if (wr_q.size() == 0 || wr_q[wr_q.size()-1].cyc != la.cyc + 1 ||
          wr_q[wr_q.size()-1].adr !== BASE || wr_q[wr_q.size()-1].dat !== 32'h0) begin
        errors++; $display("FAIL oneshot_stop_write: last write not CONTROL=0 at cycle %0d", la.cyc + 1);
      end
    end
    checks++;
    if (expire_cnt_o !== 16'd1 || err_o !== 1'b0) begin
      errors++; $display("FAIL oneshot_status: expire_cnt_o=%0d err_o=%b, required 1 and 0", expire_cnt_o, err_o);
    end
  endtask

  task automatic test_periodic();
    int n, k, np, nflag, wi, lc, exp_pulses, pi;
    clear_logs();
    ack_lat = $urandom_range(0, 4); no_ack = 0; force_flag = 0; trail_ack = 1;
    exp_pulses = PER_EN ? 5 : 1;
    do_start(32'd0, 32'd4, 1'b1, n);
    k = 0; np = 0;
    while (k < 5000) begin
      @(negedge clk); k++;
      if (expired_o) np++;
      if (np == exp_pulses || !busy_o) break;
    end
    checks++;
    if (np != exp_pulses || busy_o !== 1'b1 || expire_cnt_o !== 16'(exp_pulses)) begin
      errors++; $display("FAIL periodic_run: pulses=%0d busy=%b cnt=%0d, required %0d, 1, %0d",
                         np, busy_o, expire_cnt_o, exp_pulses, exp_pulses);
    end
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    wait_idle(200, "periodic");
    trail_ack = 0;
    nflag = 0; lc = -1; pi = 0;
    for (int i = 0; i < ack_q.size(); i++) begin
      if (!ack_q[i].flag) begin
        if (i + 1 < rd_start_q.size()) begin
          checks++;
          if (rd_start_q[i+1] != ack_q[i].cyc + 2 + POLL_GAP) begin
            errors++; $display("FAIL periodic_poll_period: read at %0d, required %0d",
                               rd_start_q[i+1], ack_q[i].cyc + 2 + POLL_GAP);
          end
        end
      end else begin
        nflag++; lc = ack_q[i].cyc;
        wi = find_wr(lc + 1);
        checks++;
        if (wi < 0 || wr_q[wi].adr !== BASE || wr_q[wi].dat !== (PER_EN ? 32'h3 : 32'h0)) begin
          errors++; $display("FAIL periodic_after_flag: no CONTROL=%0d write at cycle %0d", PER_EN ? 3 : 0, lc + 1);
        end
        checks++;
        if (pi >= pulse_q.size() || pulse_q[pi] != lc + 1) begin
          errors++; $display("FAIL periodic_pulse%0d: got %0d, required cycle %0d",
                             pi, pi < pulse_q.size() ? pulse_q[pi] : -1, lc + 1);
        end
        pi++;
        if (i + 1 < rd_start_q.size()) begin
          checks++;
          if (rd_start_q[i+1] != lc + 3 + POLL_GAP) begin
            errors++; $display("FAIL periodic_clr_period: read at %0d, required %0d", rd_start_q[i+1], lc + 3 + POLL_GAP);
          end
        end
      end
    end
    checks++;
    if (nflag != exp_pulses || pulse_q.size() != exp_pulses) begin
      errors++; $display("FAIL periodic_count: flag reads=%0d pulses=%0d, required %0d", nflag, pulse_q.size(), exp_pulses);
    end
    checks++;
    if (wr_q.size() == 0 || wr_q[wr_q.size()-1].cyc != lc + (PER_EN ? 2 : 1) || wr_q[wr_q.size()-1].dat !== 32'h0) begin
      errors++; $display("FAIL periodic_stop_write: last write not CONTROL=0 at cycle %0d", lc + (PER_EN ? 2 : 1));
    end
  endtask

  task automatic test_stop_wcmp();
    int n;
    logic [31:0] c;
    clear_logs();
    c = $urandom;
    do_start($urandom_range(0, 7), c, 1'b0, n);
    tick(2);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    wait_idle(50, "stop_wcmp");
    checks++;
    if (wr_q.size() != 4) begin
      errors++; $display("FAIL stop_wcmp_nwrites: %0d writes, required 4", wr_q.size());
    end else begin
      checks++;
      if (wr_q[2].cyc != n + 3 || wr_q[2].adr !== BASE + 32'hC || wr_q[2].dat !== c) begin
        errors++; $display("FAIL stop_wcmp_compare: cyc=%0d adr=%h dat=%h, required %0d %h %h",
                           wr_q[2].cyc, wr_q[2].adr, wr_q[2].dat, n + 3, BASE + 32'hC, c);
      end
      checks++;
      if (wr_q[3].cyc != n + 4 || wr_q[3].adr !== BASE || wr_q[3].dat !== 32'h0) begin
        errors++; $display("FAIL stop_wcmp_stop: cyc=%0d adr=%h dat=%h, required %0d %h 0",
                           wr_q[3].cyc, wr_q[3].adr, wr_q[3].dat, n + 4, BASE);
      end
    end
    checks++;
    if (rd_start_q.size() != 0 || expire_cnt_o !== 16'd0) begin
      errors++; $display("FAIL stop_wcmp_status: reads=%0d cnt=%0d, required 0 and 0", rd_start_q.size(), expire_cnt_o);
    end
  endtask

  task automatic test_stop_in_rd();
    int n, k;
    clear_logs();
    ack_lat = 5; force_flag = 1; no_ack = 0;
    do_start($urandom_range(0, 3), $urandom_range(1, 9), 1'($urandom_range(0, 1)), n);
    k = 0;
    while (!(wb_stb_o && !wb_we_o) && k < 200) begin @(negedge clk); k++; end
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    wait_idle(100, "stop_rd");
    force_flag = 0;
    checks++;
    if (ack_q.size() != 1 || pulse_q.size() != 0) begin
      errors++; $display("FAIL stop_rd_result: acks=%0d pulses=%0d, required 1 and 0", ack_q.size(), pulse_q.size());
    end else begin
      checks++;
      if (wr_q[wr_q.size()-1].cyc != ack_q[0].cyc + 1 || wr_q[wr_q.size()-1].adr !== BASE ||
          wr_q[wr_q.size()-1].dat !== 32'h0) begin
        errors++; $display("FAIL stop_rd_write: last write at %0d dat=%h, required %0d and 0",
                           wr_q[wr_q.size()-1].cyc, wr_q[wr_q.size()-1].dat, ack_q[0].cyc + 1);
      end
    end
    checks++;
    if (expire_cnt_o !== 16'd0) begin
      errors++; $display("FAIL stop_rd_cnt: expire_cnt_o=%0d, required 0", expire_cnt_o);
    end
  endtask

  task automatic test_timeout();
    int n;
    clear_logs();
    no_ack = 1;
    do_start(32'd1, 32'd3, 1'b0, n);
    wait_idle(200, "timeout");
    no_ack = 0;
    checks++;
    if (rd_cycles != ACK_TIMEOUT || ack_q.size() != 0) begin
      errors++; $display("FAIL timeout_len: stb held %0d cycles, required %0d", rd_cycles, ACK_TIMEOUT);
    end
    checks++;
    if (rd_start_q.size() != 1 || wr_q.size() == 0 || wr_q[wr_q.size()-1].cyc != rd_start_q[0] + ACK_TIMEOUT ||
        wr_q[wr_q.size()-1].dat !== 32'h0) begin
      errors++; $display("FAIL timeout_stop_write: CONTROL=0 write missing at read start + %0d", ACK_TIMEOUT);
    end
    tick(3);
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL timeout_err: err_o=%b, required 1", err_o);
    end
    force_flag = 1;
    do_start(32'd0, 32'd2, 1'b0, n);
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL timeout_err_clear: err_o=%b after start, required 0", err_o);
    end
    wait_idle(200, "timeout_restart");
    force_flag = 0;
    checks++;
    if (expire_cnt_o !== 16'd1 || err_o !== 1'b0) begin
      errors++; $display("FAIL timeout_restart: cnt=%0d err=%b, required 1 and 0", expire_cnt_o, err_o);
    end
  endtask

  task automatic test_idle_requests();
    int n;
    clear_logs();
    stop_i = 1'b1;
    tick(3);
    stop_i = 1'b0;
    tick(2);
    checks++;
    if (busy_o !== 1'b0 || wr_q.size() != 0) begin
      errors++; $display("FAIL idle_stop: busy=%b writes=%0d, required 0 and 0", busy_o, wr_q.size());
    end
    force_flag = 1;
    stop_i = 1'b1;
    do_start(32'd2, 32'd5, 1'b0, n);
    stop_i = 1'b0;
    wait_idle(200, "idle_start_stop");
    force_flag = 0;
    checks++;
    if (wr_q.size() != 6 || wr_q[1].cyc != n + 2 || wr_q[1].adr !== BASE + 32'h8 || wr_q[1].dat !== 32'd2) begin
      errors++; $display("FAIL idle_start_stop: %0d writes, required full sequence of 6", wr_q.size());
    end
  endtask

  task automatic test_busy_start_and_reset();
    int n, nrd;
    clear_logs();
    do_start(32'd0, 32'hFFFF, 1'b1, n);
    tick(6);
    prescaler_i = 32'h55; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    tick(3);
    checks++;
    if (wr_q.size() != 5 || busy_o !== 1'b1) begin
      errors++; $display("FAIL busy_start: writes=%0d busy=%b, required 5 and 1", wr_q.size(), busy_o);
    end
    nrd = rd_start_q.size();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy_o, expired_o, err_o, expire_cnt_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: busy=%b cyc=%b stb=%b adr=%h dat=%h, required all 0",
                         busy_o, wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o);
    end
    rst = 1'b0;
    tick(3 * POLL_GAP);
    checks++;
    if (wr_q.size() != 5 || rd_start_q.size() != nrd || busy_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset_quiet: writes=%0d reads=%0d busy=%b, required 5, %0d, 0",
                         wr_q.size(), rd_start_q.size(), busy_o, nrd);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (proto_err != 0) begin
      errors++; $display("FAIL protocol: %0d cycles with bad sel/cyc/address, required 0", proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot(32'd3, 32'd9, $urandom_range(0, 3));
    test_oneshot($urandom_range(0, 5), $urandom_range(1, 20), $urandom_range(0, 5));
    test_periodic();
    test_stop_wcmp();
    test_stop_in_rd();
    test_timeout();
    test_idle_requests();
    test_busy_start_and_reset();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
